// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one buffered UART transmitter among N_REQ byte-stream sources.
// The owner holds the grant for a whole frame; an owner that stalls too long is released with abort_evt.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int IDLE_TIMEOUT = 1023
) (
    input  logic               clk_100MHz,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               abort_evt,
    output logic               uart_dat_en,
    output logic [7:0]         uart_dat,
    input  logic               uart_fifo_afull,
    input  logic               uart_fifo_full
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_owner;
    logic [IDX_W-1:0] winner;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       owner_data;
    logic             any_req;
    logic             owner_valid;
    logic             owner_last;
    logic             blocked;
    logic             accept;
    logic             stall_inc;
    logic             timeout;
    logic             frame_end;
    int               rr_idx;

    assign any_req     = |req_valid;
    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];
    assign blocked     = uart_fifo_afull | uart_fifo_full;
    assign accept      = (state == XFER) & owner_valid & ~blocked;
    // A FIFO-blocked owner is never counted as stalled, whatever its valid does.
    assign stall_inc   = (state == XFER) & ~owner_valid & ~blocked;
    assign timeout     = stall_inc & (stall_cnt == CNT_W'(IDLE_TIMEOUT - 1));
    assign frame_end   = (accept & owner_last) | timeout;

    // Search from last_owner+1 upward; iterating downward lets the nearest lane win.
    always_comb begin
        winner = last_owner;
        rr_idx = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            rr_idx = (int'(last_owner) + k) % N_REQ;
            if (req_valid[rr_idx[IDX_W-1:0]]) winner = rr_idx[IDX_W-1:0];
        end
    end

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == IDX_W'(i)) owner_data = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = XFER;
            XFER:    if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[owner] = 1'b1;
        busy = (state == XFER);
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            grant       <= '0;
            owner       <= '0;
            last_owner  <= IDX_W'(N_REQ - 1);
            stall_cnt   <= '0;
            abort_evt   <= 1'b0;
            uart_dat_en <= 1'b0;
            uart_dat    <= '0;
        end else begin
            uart_dat_en <= accept;
            abort_evt   <= timeout;
            if (accept) uart_dat <= owner_data;

            if (state == IDLE) begin
                if (any_req) begin
                    owner <= winner;
                    grant <= N_REQ'(1) << winner;
                end
            end else if (frame_end) begin
                grant      <= '0;
                last_owner <= owner;
            end

            if (state == IDLE || accept || timeout) stall_cnt <= '0;
            else if (stall_inc)                     stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: queue-driven requesters, output byte monitor and
// per-scenario tasks compared against bench-side expectations.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 40;

    logic           clk_100MHz = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           abort_evt;
    logic           uart_dat_en;
    logic [7:0]     uart_dat;
    logic           uart_fifo_afull;
    logic           uart_fifo_full;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] lane_q [N][$];
    bit         lane_last_q [N][$];
    bit         lane_hold [N];
    bit         rand_mode   = 1'b0;
    bit         afull_force = 1'b0;
    int         rise_cyc [N];
    logic [7:0] out_q[$];
    int         out_cyc[$];

    uart_tx_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(TO)) dut (
        .clk_100MHz      (clk_100MHz),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .grant           (grant),
        .busy            (busy),
        .abort_evt       (abort_evt),
        .uart_dat_en     (uart_dat_en),
        .uart_dat        (uart_dat),
        .uart_fifo_afull (uart_fifo_afull),
        .uart_fifo_full  (uart_fifo_full)
    );

    always #5 clk_100MHz = ~clk_100MHz;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    // Requesters: present the head of each lane queue, pop it after a handshake.
    initial begin : driver
        logic [N-1:0] hs;
        req_valid = '0; req_data = '0; req_last = '0;
        uart_fifo_afull = 1'b0; uart_fifo_full = 1'b0;
        forever begin
            @(negedge clk_100MHz);
            hs = req_ready & req_valid;
            @(posedge clk_100MHz);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && lane_q[i].size() > 0) begin
                    lane_q[i].delete(0);
                    lane_last_q[i].delete(0);
                end
                if (lane_q[i].size() > 0 && !lane_hold[i] && !(rand_mode && $urandom_range(0, 3) == 0)) begin
                    if (!req_valid[i]) rise_cyc[i] = cyc;
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = lane_q[i][0];
                    req_last[i]        = lane_last_q[i][0];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i]        = 1'($urandom);
                end
            end
            uart_fifo_afull = afull_force || (rand_mode && $urandom_range(0, 4) == 0);
            uart_fifo_full  = rand_mode && $urandom_range(0, 19) == 0;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_100MHz);
            if (uart_dat_en) begin
                out_q.push_back(uart_dat);
                out_cyc.push_back(cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_100MHz);
        #2;
    endtask

    task automatic push_byte(input int lane, input logic [7:0] b, input bit last);
        lane_q[lane].push_back(b);
        lane_last_q[lane].push_back(last);
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0; afull_force = 1'b0; rand_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            lane_q[i].delete(); lane_last_q[i].delete(); lane_hold[i] = 1'b0;
        end
        tick();
        reset_n = 1'b1;
        tick();
        out_q.delete(); out_cyc.delete();
    endtask

    task automatic test_reset();
        push_byte(0, 8'h11, 1'b1);
        tick(); tick(); tick();
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (uart_dat_en !== 1'b0 || uart_dat !== 8'h00) begin errors++; $display("FAIL reset_uart: en=%b dat=%h want 0/00", uart_dat_en, uart_dat); end
        checks++; if (abort_evt !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", abort_evt); end
        reset_n = 1'b1;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
    endtask

    task automatic test_single_frame();
        int t = 0;
        do_reset();
        push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0); push_byte(0, 8'h43, 1'b1);
        while (out_q.size() < 3 && t < 30) begin tick(); t++; end
        checks++;
        if (out_q.size() !== 3) begin
            errors++; $display("FAIL single_count: got %0d bytes want 3", out_q.size());
        end else begin
            checks++; if (out_q[0] !== 8'h41 || out_q[1] !== 8'h42 || out_q[2] !== 8'h43) begin
                errors++; $display("FAIL single_bytes: got %h %h %h want 41 42 43", out_q[0], out_q[1], out_q[2]); end
            checks++; if (out_cyc[0] !== rise_cyc[0] + 2) begin
                errors++; $display("FAIL single_latency: first byte at %0d want %0d", out_cyc[0], rise_cyc[0] + 2); end
            checks++; if (out_cyc[1] !== out_cyc[0] + 1 || out_cyc[2] !== out_cyc[0] + 2) begin
                errors++; $display("FAIL single_b2b: cycles %0d %0d %0d not consecutive", out_cyc[0], out_cyc[1], out_cyc[2]); end
        end
        tick();
        checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single_release: grant=%b busy=%b want 0000/0", grant, busy); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_a [6] = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h80, 8'h81};
        logic [7:0] exp_b [4] = '{8'h02, 8'h03, 8'h42, 8'h43};
        int t = 0;
        do_reset();
        push_byte(0, 8'h00, 1'b0); push_byte(0, 8'h01, 1'b1);
        push_byte(1, 8'h40, 1'b0); push_byte(1, 8'h41, 1'b1);
        push_byte(2, 8'h80, 1'b0); push_byte(2, 8'h81, 1'b1);
        while (out_q.size() < 6 && t < 60) begin tick(); t++; end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_a[i]) begin
                errors++; $display("FAIL rr_order[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp_a[i]); end
        end
        tick(); tick();
        out_q.delete(); out_cyc.delete();
        push_byte(1, 8'h42, 1'b0); push_byte(1, 8'h43, 1'b1);
        push_byte(0, 8'h02, 1'b0); push_byte(0, 8'h03, 1'b1);
        t = 0;
        while (out_q.size() < 4 && t < 60) begin tick(); t++; end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_b[i]) begin
                errors++; $display("FAIL rr_wrap[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp_b[i]); end
        end
    endtask

    task automatic test_afull_hold();
        int t = 0;
        int n0, ready_bad, aborts;
        do_reset();
        for (int i = 0; i < 6; i++) push_byte(1, 8'h50 + 8'(i), i == 5);
        while (out_q.size() < 1 && t < 20) begin tick(); t++; end
        afull_force = 1'b1;
        tick(); tick();
        n0 = out_q.size(); ready_bad = 0; aborts = 0;
        for (int c = 0; c < 50; c++) begin
            if (c == 5) lane_hold[1] = 1'b1;
            tick();
            if (req_ready !== '0) ready_bad++;
            if (abort_evt === 1'b1) aborts++;
        end
        checks++; if (out_q.size() !== n0) begin errors++; $display("FAIL afull_no_output: got %0d bytes want %0d", out_q.size(), n0); end
        checks++; if (ready_bad !== 0) begin errors++; $display("FAIL afull_ready: ready high in %0d cycles want 0", ready_bad); end
        checks++; if (aborts !== 0 || busy !== 1'b1) begin errors++; $display("FAIL afull_no_abort: aborts=%0d busy=%b want 0/1", aborts, busy); end
        afull_force = 1'b0; lane_hold[1] = 1'b0;
        t = 0;
        while (out_q.size() < 6 && t < 40) begin tick(); t++; end
        checks++;
        if (out_q.size() !== 6) begin
            errors++; $display("FAIL afull_resume_count: got %0d bytes want 6", out_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (out_q[i] !== 8'h50 + 8'(i)) begin errors++; $display("FAIL afull_resume[%0d]: got %h want %h", i, out_q[i], 8'h50 + 8'(i)); end
            end
        end
    endtask

    task automatic test_timeout();
        int t = 0;
        int t_acc, abort_cyc, pulses;
        logic [N-1:0] grant_after;
        do_reset();
        push_byte(2, 8'h90, 1'b0);
        while (out_q.size() < 1 && t < 20) begin tick(); t++; end
        t_acc = out_cyc[0];
        push_byte(3, 8'hC0, 1'b0); push_byte(3, 8'hC1, 1'b1);
        abort_cyc = -1; pulses = 0; grant_after = 'x;
        for (int c = 0; c < TO + 10; c++) begin
            tick();
            if (abort_evt === 1'b1) begin
                pulses++;
                if (abort_cyc < 0) abort_cyc = cyc;
            end
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) grant_after = grant;
        end
        checks++; if (abort_cyc !== t_acc + TO) begin errors++; $display("FAIL timeout_cycle: abort at %0d want %0d", abort_cyc, t_acc + TO); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL timeout_pulse: %0d pulses want 1", pulses); end
        checks++; if (grant_after !== 4'b1000) begin errors++; $display("FAIL timeout_next_grant: got %b want 1000", grant_after); end
        t = 0;
        while (out_q.size() < 3 && t < 20) begin tick(); t++; end
        checks++; if (out_q.size() !== 3 || out_q[1] !== 8'hC0 || out_q[2] !== 8'hC1) begin
            errors++; $display("FAIL timeout_lane3_bytes: got %0d bytes want 90 C0 C1", out_q.size()); end
    endtask

    task automatic test_mid_reset();
        int t = 0;
        int n0;
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(2, 8'hA0 + 8'(i), i == 4);
        while (out_q.size() < 2 && t < 20) begin tick(); t++; end
        push_byte(0, 8'h01, 1'b1); push_byte(1, 8'h41, 1'b1); push_byte(3, 8'hC1, 1'b1);
        tick();
        reset_n = 1'b0;
        tick();
        n0 = out_q.size();
        checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_grant: grant=%b busy=%b want 0000/0", grant, busy); end
        checks++; if (uart_dat_en !== 1'b0 || uart_dat !== 8'h00) begin errors++; $display("FAIL midreset_uart: en=%b dat=%h want 0/00", uart_dat_en, uart_dat); end
        checks++; if (req_ready !== '0 || abort_evt !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: ready=%b abort=%b want 0000/0", req_ready, abort_evt); end
        reset_n = 1'b1;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midreset_lane0_first: got %b want 0001", grant); end
        t = 0;
        while (out_q.size() < n0 + 1 && t < 20) begin tick(); t++; end
        checks++; if (out_q.size() < n0 + 1 || out_q[n0] !== 8'h01) begin errors++; $display("FAIL midreset_first_byte: got %0d bytes want 01 at index %0d", out_q.size(), n0); end
        t = 0;
        while ((lane_q[0].size() + lane_q[1].size() + lane_q[2].size() + lane_q[3].size() > 0 || busy) && t < 200) begin tick(); t++; end
    endtask

    task automatic test_random_traffic();
        logic [7:0] exp_b [N][$];
        bit         exp_l [N][$];
        int total = 0, got = 0, t = 0, cur_lane = -1, lane;
        bit prev_block = 1'b0;
        do_reset();
        for (int l = 0; l < N; l++) begin
            int seq = 0;
            for (int f = 0; f < 8; f++) begin
                int len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    logic [7:0] v;
                    v = {2'(l), 6'(seq)};
                    seq++; total++;
                    push_byte(l, v, b == len - 1);
                    exp_b[l].push_back(v);
                    exp_l[l].push_back(b == len - 1);
                end
            end
        end
        rand_mode = 1'b1;
        while (got < total && t < 4000) begin
            tick(); t++;
            checks++; if (!$onehot0(grant) || busy !== (grant != '0) || (req_ready & ~grant) != '0) begin
                errors++; $display("FAIL rand_invariant: grant=%b busy=%b ready=%b", grant, busy, req_ready); end
            if (uart_dat_en === 1'b1) begin
                got++;
                lane = int'(uart_dat[7:6]);
                checks++; if (prev_block) begin errors++; $display("FAIL rand_afull_accept: byte %h accepted while blocked", uart_dat); end
                checks++;
                if (exp_b[lane].size() == 0 || uart_dat !== exp_b[lane][0]) begin
                    errors++; $display("FAIL rand_order: lane %0d got %h want %h", lane, uart_dat, (exp_b[lane].size() > 0) ? exp_b[lane][0] : 8'hxx);
                end else begin
                    checks++; if (cur_lane >= 0 && cur_lane != lane) begin errors++; $display("FAIL rand_atomic: lane %0d byte inside lane %0d frame", lane, cur_lane); end
                    cur_lane = exp_l[lane][0] ? -1 : lane;
                    exp_b[lane].delete(0); exp_l[lane].delete(0);
                end
            end
            prev_block = uart_fifo_afull | uart_fifo_full;
        end
        rand_mode = 1'b0;
        checks++; if (got !== total) begin errors++; $display("FAIL rand_complete: got %0d bytes want %0d", got, total); end
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin lane_hold[i] = 1'b0; rise_cyc[i] = 0; end
        test_reset();
        test_single_frame();
        test_round_robin();
        test_afull_hold();
        test_timeout();
        test_mid_reset();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
